// File: rtl/cod_mem_pkg.sv
// Shared constants and loader state encoding for the CPU memory loader.
package cod_mem_pkg;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } ld_state_e;
endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; byte k lands in bits [8k+7:8k].
module byte_packer
    import cod_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              strobe_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_full_o
);
    logic [1:0]        byte_idx_q;
    logic [DATA_W-1:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q <= 2'd0;
            word_q     <= '0;
        end else if (clear_i) begin
            byte_idx_q <= 2'd0;
        end else if (strobe_i) begin
            word_q[{byte_idx_q, 3'b000} +: 8] <= byte_i;
            byte_idx_q                        <= byte_idx_q + 2'd1;
        end
    end

    // Combinational so the FSM can leave COLLECT on the same edge that stores lane 3.
    assign word_full_o = strobe_i && (byte_idx_q == 2'd3);
    assign word_o      = word_q;
endmodule

// File: rtl/mem_loader.sv
// Memory-port owner: CPU pass-through in IDLE, byte-stream block loader otherwise.
// Optional running checksum of written words under MEM_LOADER_CHECKSUM_EN.
module mem_loader
    import cod_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);
    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              start_load;
    logic              strobe;
    logic              word_full;
    logic              pack_clear;
    logic [DATA_W-1:0] packed_word;

    assign start_load = (state_q == ST_IDLE) && start;
    assign in_ready   = (state_q == ST_COLLECT);
    assign strobe     = in_valid && (state_q == ST_COLLECT);
    assign pack_clear = start_load || (state_q == ST_WRITE);
    assign busy       = (state_q != ST_IDLE);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (pack_clear),
        .strobe_i   (strobe),
        .byte_i     (in_byte),
        .word_o     (packed_word),
        .word_full_o(word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        done        = 1'b0;
        mem_addr    = cur_addr_q;
        mem_we      = 1'b0;
        mem_wdata   = packed_word;
        case (state_q)
            ST_IDLE: begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
                if (start) begin
                    cur_addr_d  = base_addr;
                    remaining_d = word_count;
                    state_d     = (word_count != '0) ? ST_COLLECT : ST_DONE;
                end
            end
            ST_COLLECT: begin
                if (word_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // Address wraps naturally at DEPTH through the ADDR_W-bit register.
                mem_we      = 1'b1;
                cur_addr_d  = cur_addr_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                state_d     = (remaining_q == (ADDR_W + 1)'(1)) ? ST_DONE : ST_COLLECT;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (start_load) begin
            checksum_q <= '0;
        end else if (state_q == ST_WRITE) begin
            checksum_q <= checksum_q + packed_word;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif
endmodule
